// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes a packed hex value onto a common-segment 7-segment display.
//   The value is captured once per scan frame at slot 0, cycle 0. All digits of
//   one frame therefore come from the same capture. Each digit slot lasts DWELL
//   cycles. The first cycle of a slot is dark so the previous digit does not
//   ghost onto the next one. Leading-zero digits can be blanked.
//
// Ports
//   ledclk      in   display refresh clock, rising edge
//   rst         in   asynchronous reset, active low
//   en          in   scan enable; low keeps the display dark and restarts the scan
//   blank_lz    in   1 = blank leading zero digits (digit 0 always shown)
//   value       in   nibble i drives digit i, nibble 0 least significant
//   abcdefg     out  segments, active high, bit6 = a ... bit0 = g
//   digit       out  one-hot digit select, active high, all-zero = dark
//   frame_start out  one-cycle pulse on the edge that takes a new snapshot
//
// Timing contract: there is no handshake. Every output is registered and is
// valid every cycle. The producer must hold value stable for at least one
// ledclk cycle around the frame boundary, because value is sampled as a plain
// multi-bit bus.
module seg7_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL      = 4
) (
   input  logic                    ledclk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    blank_lz,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [6:0]              abcdefg,
   output logic [NUM_DIGITS-1:0]   digit,
   output logic                    frame_start
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(DWELL);

   logic [IW-1:0]           idx;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] snap;

   logic [3:0]              cur_nib;
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic [NUM_DIGITS-1:0]   sel_onehot;
   logic                    cur_lz;
   logic                    blanked;
   logic                    slot_end;
   logic                    frame_edge;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h7E;
         4'h1: decode = 7'h30;
         4'h2: decode = 7'h6D;
         4'h3: decode = 7'h79;
         4'h4: decode = 7'h33;
         4'h5: decode = 7'h5B;
         4'h6: decode = 7'h5F;
         4'h7: decode = 7'h70;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h7B;
         4'hA: decode = 7'h77;
         4'hB: decode = 7'h1F;
         4'hC: decode = 7'h4E;
         4'hD: decode = 7'h3D;
         4'hE: decode = 7'h4F;
         default: decode = 7'h47;
      endcase
   endfunction

   // Select the current nibble and its one-hot digit line. lead_zero[i] is set
   // when nibbles i..NUM_DIGITS-1 of the snapshot are all zero.
   always_comb begin
      logic acc;
      cur_nib    = 4'h0;
      sel_onehot = '0;
      cur_lz     = 1'b0;
      lead_zero  = '0;
      acc        = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         acc          = acc & (snap[4*i +: 4] == 4'h0);
         lead_zero[i] = acc;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib       = snap[4*i +: 4];
            sel_onehot[i] = 1'b1;
            cur_lz        = lead_zero[i];
         end
      end
   end

   assign blanked    = blank_lz && (idx != '0) && cur_lz;
   assign slot_end   = (cnt == CW'(DWELL - 1));
   assign frame_edge = (idx == '0) && (cnt == '0);

   // Scan counters. Holding them at zero while disabled makes the first
   // enabled edge start a fresh frame.
   always_ff @(posedge ledclk or negedge rst) begin
      if (!rst) begin
         idx <= '0;
         cnt <= '0;
      end else if (!en) begin
         idx <= '0;
         cnt <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Snapshot register. It keeps its content while disabled.
   always_ff @(posedge ledclk or negedge rst) begin
      if (!rst) begin
         snap <= '0;
      end else if (en && frame_edge) begin
         snap <= value;
      end
   end

   // Output registers. cnt == 0 is the dark gap at the start of each slot.
   // The frame edge also falls in a dark cycle, so the new snapshot is
   // first displayed on the following cycle.
   always_ff @(posedge ledclk or negedge rst) begin
      if (!rst) begin
         abcdefg     <= '0;
         digit       <= '0;
         frame_start <= 1'b0;
      end else if (!en) begin
         abcdefg     <= '0;
         digit       <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_edge;
         if (cnt == '0 || blanked) begin
            abcdefg <= '0;
            digit   <= '0;
         end else begin
            abcdefg <= decode(cur_nib);
            digit   <= sel_onehot;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Bench for seg7_scan_driver (NUM_DIGITS = 4, DWELL = 4).
//   At each rising edge, a reference model predicts the registered outputs
//   and pushes them into exp_q. At each falling edge, a monitor pops one entry
//   and compares it with the DUT outputs. The model works from the frame
//   position count, not from slot or cycle counters.
module tb_seg7_scan_driver;

   localparam int N     = 4;
   localparam int DW    = 4;
   localparam int FRAME = N * DW;
   localparam int EW    = 1 + N + 7;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic              ledclk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              blank_lz = 1'b0;
   logic [4*N-1:0]    value = '0;
   logic [6:0]        abcdefg;
   logic [N-1:0]      digit;
   logic              frame_start;

   int                errors = 0;
   int                checks = 0;

   logic [EW-1:0]     exp_q[$];

   seg7_scan_driver #(.NUM_DIGITS(N), .DWELL(DW)) dut (
      .ledclk      (ledclk),
      .rst         (rst),
      .en          (en),
      .blank_lz    (blank_lz),
      .value       (value),
      .abcdefg     (abcdefg),
      .digit       (digit),
      .frame_start (frame_start)
   );

   // Clock and reset
   always #5 ledclk = ~ledclk;

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got fs=%0b digit=%b seg=%h, expected fs=%0b digit=%b seg=%h",
                  name, $time, act[EW-1], act[EW-2 -: N], act[6:0],
                  exp[EW-1], exp[EW-2 -: N], exp[6:0]);
      end
   endtask

   // Reference model. t counts the enabled edges since the scan last
   // restarted. The frame position is t mod FRAME.
   int             t = 0;
   logic [4*N-1:0] m_snap = '0;

   always @(negedge rst) begin
      t = 0;
      m_snap = '0;
      exp_q.delete();
   end

   always @(posedge ledclk) begin
      int pos, slot, ph;
      logic lit;
      logic [EW-1:0] e;
      if (rst) begin
         if (!en) begin
            t = 0;
            exp_q.push_back('0);
         end else begin
            pos  = t % FRAME;
            slot = pos / DW;
            ph   = pos % DW;
            if (pos == 0) m_snap = value;
            lit = (ph != 0) && !(blank_lz && slot > 0 && ((m_snap >> (4 * slot)) == 0));
            e = '0;
            e[EW-1] = (pos == 0);
            if (lit) begin
               e[EW-2 -: N] = N'(1) << slot;
               e[6:0]       = SEG_TAB[(m_snap >> (4 * slot)) & 4'hF];
            end
            exp_q.push_back(e);
            t++;
         end
      end
   end

   // Monitor and scoreboard
   always @(negedge ledclk) begin
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("scan", {frame_start, digit, abcdefg}, e);
      end else if (!rst) begin
         check("reset_out", {frame_start, digit, abcdefg}, '0);
      end
      checks++;
      if (!$onehot0(digit)) begin
         errors++;
         $display("FAIL onehot0 at %0t: digit=%b, expected at most one bit set", $time, digit);
      end
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge ledclk);
      #2;
   endtask

   // Stimulus
   initial begin
      // Reset held with an all-ones value and enable high.
      value = 16'hFFFF;
      en = 1'b1;
      tick(3);
      #1 check("reset_between_edges", {frame_start, digit, abcdefg}, '0);

      // Basic scan order, no blanking.
      value = 16'h1234;
      blank_lz = 1'b0;
      rst = 1'b1;
      tick(2 * FRAME);

      // Leading-zero blanking with several values.
      blank_lz = 1'b1;
      value = 16'h0007; tick(2 * FRAME);
      value = 16'h0000; tick(2 * FRAME);
      value = 16'h0070; tick(2 * FRAME);
      value = 16'h0500; tick(2 * FRAME);

      // Change value mid-frame. The new value appears only in the next frame.
      blank_lz = 1'b0;
      value = 16'h1234;
      tick(FRAME - (t % FRAME));
      tick(2 * DW + 1);
      value = 16'hABCD;
      tick(2 * FRAME);

      // Drop enable mid-slot for 3 cycles.
      tick(DW + 2);
      en = 1'b0;
      tick(3);
      en = 1'b1;
      tick(2 * FRAME);

      // Asynchronous reset in the middle of a frame.
      tick(DW + 1);
      rst = 1'b0;
      #1 check("async_rst_immediate", {frame_start, digit, abcdefg}, '0);
      tick(2);
      rst = 1'b1;
      value = 16'h1234;
      tick(2 * FRAME);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) value = 16'($urandom);
         if ($urandom_range(0, 31) == 0) value = 16'($urandom_range(0, 255));
         if ($urandom_range(0, 23) == 0) blank_lz = 1'($urandom);
         if ($urandom_range(0, 29) == 0) en = ~en;
         if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b0;
            #1 check("async_rst_random", {frame_start, digit, abcdefg}, '0);
            tick(1);
            rst = 1'b1;
         end
         tick(1);
      end

      @(negedge ledclk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
